hidden_layer: RTL and testbench
===============================

# hidden_layer

Fully-connected hidden layer that produces the packed activation vector and start strobe consumed by the output layer. It captures one input feature vector, runs HIDDEN_SIZE parallel signed multiply-accumulate lanes over INPUT_SIZE cycles (one input element per cycle), applies ReLU, and presents the result on `hidden_out_flat` with a level `done`. It sits between the input/feature buffer and the output layer. `done` drives the output layer's `start`, which is edge-detected on that side.

## Interface
Parameters (from nn_arch_pkg, listed here with package values):
- INPUT_SIZE, 64: input features per inference.
- HIDDEN_SIZE, 16: hidden neurons, equal to the number of MAC lanes.
- DATA_W, 8: width of data_t (signed input and weight type).
- ACC_W, 24: width of acc_t (signed accumulator, bias and activation type).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; only a 0→1 transition is acted on.
- x_in_flat  in  DATA_W*INPUT_SIZE  input vector; element k is at [(k+1)*DATA_W-1 -: DATA_W].
- weight  in  data_t[INPUT_SIZE][HIDDEN_SIZE]  weight from input k to neuron j.
- bias  in  acc_t[HIDDEN_SIZE]  per-neuron bias.
- hidden_out_flat  out  ACC_W*HIDDEN_SIZE  ReLU activations; neuron j is at [(j+1)*ACC_W-1 -: ACC_W].
- done  out  1  result valid; a level, held until the next accepted start.
- busy  out  1  high while a computation is in flight.

## Operation
- Start edge: a registered copy `start_d` gives `start_pulse = start & ~start_d`. A level held on `start` is accepted only once.
- FSM states: IDLE, MAC, WRITE.
  - IDLE + start_pulse: capture x_in_flat into x_reg, set acc[j] = bias[j], set k = 0, go to MAC, busy=1, done=0.
  - MAC: each cycle, acc[j] += sext(x_reg[k] * weight[k][j]) for all j; k increments. On the cycle with k == INPUT_SIZE-1, go to WRITE.
  - WRITE: hidden_out[j] = (acc[j] < 0) ? 0 : acc[j]; done=1, busy=0; return to IDLE.
- Arithmetic:
  - The product is signed DATA_W×DATA_W giving 2*DATA_W bits, sign-extended to ACC_W.
  - The accumulator wraps in ACC_W two's complement; there is no saturation.
  - ReLU tests the MSB of the wrapped accumulator.
- x_reg is captured at start. Changes on x_in_flat mid-run have no effect. `weight` and `bias` must be held stable from start until done.
- start_pulse while in MAC or WRITE: ignored, not queued.
- start_pulse in IDLE while done=1: accepted. done drops to 0 on the accept edge. hidden_out_flat keeps the old result until the new WRITE.
- k counter width is $clog2(INPUT_SIZE). k is never read past INPUT_SIZE-1.

## Timing
- Reset values: hidden_out_flat=0, done=0, busy=0, state=IDLE, start_d=0, k=0, acc=0, x_reg=0.
- Edge E0 samples start_pulse. MAC edges are E1..E_INPUT_SIZE. WRITE is E_(INPUT_SIZE+1).
- done and hidden_out_flat are valid after E_(INPUT_SIZE+1): latency INPUT_SIZE+1 = 65 cycles.
- busy is high from after E0 through E_(INPUT_SIZE+1), i.e. INPUT_SIZE+1 cycles.
- Back-to-back: the earliest new start is accepted at the edge after WRITE, giving throughput of one inference per INPUT_SIZE+2 cycles when start is toggled.
- done rises once per inference. The output layer's edge detector therefore triggers exactly once.
- Reset mid-operation: rst_n low immediately forces all reset values. The partial result is discarded and done does not assert. After release, the block waits for a fresh 0→1 on start. If start is still high at release, start_d is 0, so that counts as an edge and is accepted.

## Test plan
- Reset: assert rst_n mid-MAC (cycle 30) → all outputs 0 immediately. Re-run with a fresh start gives the correct result 65 cycles later.
- Identity-like: x[k]=1 for all k, weight[k][j]=1, bias[j]=j → hidden_out[j]=64+j, done high exactly at cycle 65 after the start edge, busy high cycles 1–65.
- ReLU/sign: x[k]=-128, weight[k][0]=127, bias[0]=100 → acc=-1040284 → hidden_out[0]=0. With weight[k][1]=-128 → hidden_out[1]=1048576.
- Wrap: x[k]=-128, weight[k][j]=-128, bias[j]=0x7FFFFF → 0x7FFFFF+1048576 wraps to -7340033, so hidden_out=0 (no saturation).
- Start while busy: a second start pulse at cycle 20 → ignored, with a single done rise at cycle 65. Holding start high for 200 cycles → one inference only.
- Back-to-back with x_in_flat changed after E0: results match the captured x. Restart while done=1 → done falls on the accept edge, and the old hidden_out persists until the new done.

Source files
------------

// File: rtl/hidden_layer.sv
// hidden_layer: fully-connected layer, HIDDEN_SIZE signed MAC lanes,
// one input element per cycle, ReLU on the wrapped accumulator.
package nn_arch_pkg;
  localparam int INPUT_SIZE  = 64;
  localparam int HIDDEN_SIZE = 16;
  localparam int DATA_W      = 8;
  localparam int ACC_W       = 24;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
endpackage

module hidden_layer
  import nn_arch_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DATA_W*INPUT_SIZE-1:0]  x_in_flat,
  input  data_t                         weight [INPUT_SIZE][HIDDEN_SIZE],
  input  acc_t                          bias [HIDDEN_SIZE],
  output logic [ACC_W*HIDDEN_SIZE-1:0]  hidden_out_flat,
  output logic                          done,
  output logic                          busy
);

  localparam int KW = $clog2(INPUT_SIZE);
  localparam int PW = 2 * DATA_W;

  typedef logic [KW-1:0] k_t;
  localparam k_t K_LAST = k_t'(INPUT_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE
  } state_t;

  state_t state, state_n;
  logic   start_d;
  logic   start_pulse;
  k_t     k;
  data_t  x_reg [INPUT_SIZE];
  acc_t   acc [HIDDEN_SIZE];

  data_t             x_k;
  logic signed [PW-1:0] prod [HIDDEN_SIZE];
  acc_t              acc_nx [HIDDEN_SIZE];

  assign start_pulse = start & ~start_d;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_pulse) state_n = MAC;
      MAC:     if (k == K_LAST) state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Product is full 2*DATA_W, then sign-extended; sum wraps in ACC_W.
  always_comb begin
    x_k = x_reg[k];
    for (int j = 0; j < HIDDEN_SIZE; j++) begin
      prod[j]   = PW'(x_k) * PW'(weight[k][j]);
      acc_nx[j] = acc[j] + ACC_W'(prod[j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d         <= 1'b0;
      k               <= '0;
      done            <= 1'b0;
      busy            <= 1'b0;
      hidden_out_flat <= '0;
      for (int i = 0; i < INPUT_SIZE; i++) x_reg[i] <= '0;
      for (int j = 0; j < HIDDEN_SIZE; j++) acc[j] <= '0;
    end else begin
      start_d <= start;
      unique case (state)
        IDLE: begin
          if (start_pulse) begin
            k    <= '0;
            done <= 1'b0;
            busy <= 1'b1;
            for (int i = 0; i < INPUT_SIZE; i++)
              x_reg[i] <= x_in_flat[i*DATA_W +: DATA_W];
            for (int j = 0; j < HIDDEN_SIZE; j++)
              acc[j] <= bias[j];
          end
        end
        MAC: begin
          k <= k + k_t'(1);
          for (int j = 0; j < HIDDEN_SIZE; j++)
            acc[j] <= acc_nx[j];
        end
        WRITE: begin
          done <= 1'b1;
          busy <= 1'b0;
          // ReLU keys off the MSB of the wrapped sum
          for (int j = 0; j < HIDDEN_SIZE; j++)
            hidden_out_flat[j*ACC_W +: ACC_W] <=
              acc[j][ACC_W-1] ? '0 : acc[j];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer.sv
// tb_hidden_layer: scoreboard bench for hidden_layer, expected
// vectors queued at start and compared on each done rise.
module tb_hidden_layer;
  import nn_arch_pkg::*;

  localparam int OUT_W = ACC_W * HIDDEN_SIZE;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic [DATA_W*INPUT_SIZE-1:0] x_in_flat;
  data_t                        weight [INPUT_SIZE][HIDDEN_SIZE];
  acc_t                         bias [HIDDEN_SIZE];
  logic [OUT_W-1:0]             hidden_out_flat;
  logic                         done;
  logic                         busy;

  data_t            xs [INPUT_SIZE];
  logic [OUT_W-1:0] sb [$];
  logic [OUT_W-1:0] last_exp = '0;
  int               checks = 0;
  int               fails = 0;
  int               rises = 0;

  hidden_layer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .x_in_flat       (x_in_flat),
    .weight          (weight),
    .bias            (bias),
    .hidden_out_flat (hidden_out_flat),
    .done            (done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    x_in_flat = '0;
    for (int k = 0; k < INPUT_SIZE; k++)
      x_in_flat[k*DATA_W +: DATA_W] = xs[k];
  end

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] model();
    logic [OUT_W-1:0] r;
    longint           s;
    logic [ACC_W-1:0] a;
    r = '0;
    for (int j = 0; j < HIDDEN_SIZE; j++) begin
      s = longint'(bias[j]);
      for (int k = 0; k < INPUT_SIZE; k++)
        s += longint'(xs[k]) * longint'(weight[k][j]);
      a = s[ACC_W-1:0];
      r[j*ACC_W +: ACC_W] = a[ACC_W-1] ? '0 : a;
    end
    return r;
  endfunction

  function automatic longint hid(input int j);
    return longint'(hidden_out_flat[j*ACC_W +: ACC_W]);
  endfunction

  // Scoreboard consumer: one pop per done rise
  initial begin
    logic             done_q;
    logic [OUT_W-1:0] e;
    done_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done && !done_q) begin
        rises++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          for (int j = 0; j < HIDDEN_SIZE; j++)
            chk($sformatf("out[%0d]", j), hid(j),
                longint'(e[j*ACC_W +: ACC_W]));
        end
      end
      done_q = done;
    end
  end

  task automatic fill(input int xv, input int wv, input int bv);
    for (int k = 0; k < INPUT_SIZE; k++) begin
      xs[k] = data_t'(xv);
      for (int j = 0; j < HIDDEN_SIZE; j++)
        weight[k][j] = data_t'(wv);
    end
    for (int j = 0; j < HIDDEN_SIZE; j++) bias[j] = acc_t'(bv);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < INPUT_SIZE; k++) begin
      xs[k] = data_t'($urandom);
      for (int j = 0; j < HIDDEN_SIZE; j++)
        weight[k][j] = data_t'($urandom);
    end
    for (int j = 0; j < HIDDEN_SIZE; j++)
      bias[j] = acc_t'($urandom_range(0, 200000)) - acc_t'(100000);
  endtask

  // Start is raised #1 after an edge, so the next edge is E0.
  task automatic run(input bit chg_x, input bit glitch);
    logic [OUT_W-1:0] e;
    int               n;
    int               bc;
    int               r0;
    e  = model();
    r0 = rises;
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("e0_busy", busy, 1);
    chk("e0_done", done, 0);
    chk("e0_hold_old", longint'(hidden_out_flat != last_exp), 0);
    if (chg_x)
      for (int k = 0; k < INPUT_SIZE; k++) xs[k] = data_t'($urandom);
    n  = 0;
    bc = 1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (glitch) start = (n == 20);
      if (busy) bc++;
      if (n == 40)
        chk("mid_hold_old", longint'(hidden_out_flat != last_exp), 0);
    end while (!done && n < 200);
    start = 1'b0;
    chk("latency", n, 65);
    chk("busy_cycles", bc, 65);
    @(negedge clk);
    chk("done_rises", rises - r0, 1);
    last_exp = e;
  endtask

  initial begin
    int r0;
    fill(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_nz", longint'(hidden_out_flat != '0), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    fill(1, 1, 0);
    for (int j = 0; j < HIDDEN_SIZE; j++) bias[j] = acc_t'(j);
    run(1'b0, 1'b1);
    for (int j = 0; j < HIDDEN_SIZE; j++)
      chk($sformatf("ident[%0d]", j), hid(j), 64 + j);

    fill(-128, 5, 0);
    for (int k = 0; k < INPUT_SIZE; k++) begin
      weight[k][0] = 8'sd127;
      weight[k][1] = -8'sd128;
    end
    bias[0] = 24'sd100;
    run(1'b0, 1'b0);
    chk("relu_neg", hid(0), 0);
    chk("neg_x_neg", hid(1), 1048576);

    fill(-128, -128, 24'h7FFFFF);
    run(1'b0, 1'b0);
    chk("wrap", hid(3), 0);

    fill_rand();
    run(1'b1, 1'b0);
    fill_rand();
    run(1'b1, 1'b0);

    // start held high for 200 cycles runs once
    fill_rand();
    sb.push_back(model());
    r0 = rises;
    start = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    start = 1'b0;
    chk("hold_rises", rises - r0, 1);
    chk("done_level", done, 1);
    last_exp = sb.size() == 0 ? last_exp : '0;
    for (int j = 0; j < HIDDEN_SIZE; j++)
      last_exp[j*ACC_W +: ACC_W] = hidden_out_flat[j*ACC_W +: ACC_W];

    // reset in the middle of MAC discards the run
    fill_rand();
    sb.push_back(model());
    r0 = rises;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_out_nz", longint'(hidden_out_flat != '0), 0);
    sb.delete();
    last_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("rst_no_done", rises - r0, 0);
    chk("rst_idle_busy", busy, 0);

    fill_rand();
    run(1'b0, 1'b0);

    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
